// File: rtl/xy_outport_arbiter.sv
// Round-robin arbiter and one-packet output sequencer for a single xy_switch output port.
// Pops the winning input FIFO head into pckt_o and streams it to the downstream FIFO.
module xy_outport_arbiter #(
    parameter int                PORT_N   = 5,
    parameter int                PCKT_W   = 12,
    parameter logic [PORT_N-1:0] REQ_MASK = '1
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [PORT_N-1:0]        req_i,
    input  logic [PORT_N*PCKT_W-1:0] pckt_i,
    output logic [PORT_N-1:0]        rd_en_o,
    output logic [PORT_N-1:0]        grant_o,
    output logic [PCKT_W-1:0]        pckt_o,
    output logic                     wr_en_o,
    input  logic                     nxt_fifo_full_i,
    input  logic                     nxt_fifo_overflow_i,
    output logic                     ovrflw_err_o
);

    localparam int PTR_W = (PORT_N > 1) ? $clog2(PORT_N) : 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SEND = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [PTR_W-1:0]  ptr_q, ptr_d;
    logic [PCKT_W-1:0] pckt_q, pckt_d;
    logic [PORT_N-1:0] grant_q, grant_d;
    logic              ovrflw_q, ovrflw_d;

    logic [PORT_N-1:0] maskedReq;
    logic [PTR_W-1:0]  winIdx;
    logic [PTR_W-1:0]  candIdx;
    logic              winFound;
    logic              grantValid;
    logic [PORT_N-1:0] winOneHot;
    logic [PCKT_W-1:0] pcktSlice [PORT_N];
    int                cand;

    for (genvar i = 0; i < PORT_N; i++) begin : g_slice
        assign pcktSlice[i] = pckt_i[PCKT_W*i +: PCKT_W];
    end

    assign maskedReq = req_i & REQ_MASK;

    // Scan from the pointer upward with wrap; the first requester found wins.
    always_comb begin
        winIdx   = '0;
        winFound = 1'b0;
        cand     = 0;
        candIdx  = '0;
        for (int k = 0; k < PORT_N; k++) begin
            cand = int'(ptr_q) + k;
            if (cand >= PORT_N) begin
                cand = cand - PORT_N;
            end
            candIdx = PTR_W'(cand);
            if (!winFound && maskedReq[candIdx]) begin
                winFound = 1'b1;
                winIdx   = candIdx;
            end
        end
    end

    always_comb begin
        winOneHot         = '0;
        winOneHot[winIdx] = 1'b1;
    end

    // Granting only when downstream is not full keeps at most one packet pending.
    assign grantValid = !nxt_fifo_full_i && winFound && !rst_i;

    assign rd_en_o = grantValid ? winOneHot : '0;
    assign wr_en_o = (state_q != ST_IDLE) && !nxt_fifo_full_i && !rst_i;

    always_comb begin
        pckt_d   = pckt_q;
        grant_d  = grant_q;
        ptr_d    = ptr_q;
        ovrflw_d = ovrflw_q | nxt_fifo_overflow_i;
        if (grantValid) begin
            pckt_d  = pcktSlice[winIdx];
            grant_d = winOneHot;
            ptr_d   = (winIdx == PTR_W'(PORT_N - 1)) ? '0 : winIdx + 1'b1;
        end
    end

    always_comb begin
        state_d = ST_IDLE;
        if ((state_q != ST_IDLE) && nxt_fifo_full_i) begin
            state_d = ST_HOLD;
        end else if (grantValid) begin
            state_d = ST_SEND;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= ST_IDLE;
            ptr_q    <= '0;
            pckt_q   <= '0;
            grant_q  <= '0;
            ovrflw_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            pckt_q   <= pckt_d;
            grant_q  <= grant_d;
            ovrflw_q <= ovrflw_d;
        end
    end

    assign pckt_o       = pckt_q;
    assign grant_o      = grant_q;
    assign ovrflw_err_o = ovrflw_q;

endmodule
